// File: rtl/vga_timing_gen.sv
// Video timing generator: porch-parameterised HS/VS/BLANK with a FIFO-fed pixel stream
// or built-in test patterns, frame-aligned mode changes, underflow flag and frame counter.
module vga_timing_gen #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29,
  parameter int GRID   = 16
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  input  logic        underflow_clr,
  input  logic [31:0] fifo_rdata,
  input  logic        fifo_rempty,
  input  logic        fifo_primed,
  output logic        fifo_read,
  output logic        HS,
  output logic        VS,
  output logic        BLANK,
  output logic [23:0] RGB,
  output logic        frame_start,
  output logic        underflow,
  output logic [15:0] frame_cnt
);

  localparam int HSUP  = HFP + HPULSE + HBP;
  localparam int HSIZE = HSUP + HDISP;
  localparam int VSUP  = VFP + VPULSE + VBP;
  localparam int VSIZE = VSUP + VDISP;
  localparam int HW    = $clog2(HSIZE);
  localparam int VW    = $clog2(VSIZE);
  localparam int BAR_W = HDISP / 8;

  localparam logic [HW-1:0] H_LAST = HW'(HSIZE - 1);
  localparam logic [HW-1:0] H_SUP  = HW'(HSUP);
  localparam logic [HW-1:0] H_PS   = HW'(HFP);
  localparam logic [HW-1:0] H_PE   = HW'(HFP + HPULSE);
  localparam logic [VW-1:0] V_LAST = VW'(VSIZE - 1);
  localparam logic [VW-1:0] V_SUP  = VW'(VSUP);
  localparam logic [VW-1:0] V_PS   = VW'(VFP);
  localparam logic [VW-1:0] V_PE   = VW'(VFP + VPULSE);

  localparam logic [1:0] ST_WAIT_PRIME = 2'd0;
  localparam logic [1:0] ST_STREAM     = 2'd1;
  localparam logic [1:0] ST_PATTERN    = 2'd2;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [1:0]    mode_q;
  logic          started;

  logic          active;
  logic          boundary;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic [HW-1:0] bar_full;
  logic [2:0]    bar_idx;
  logic [23:0]   pattern_rgb;
  logic [23:0]   pixel_next;
  logic          unused_rdata_bits;

  assign unused_rdata_bits = ^fifo_rdata[31:24];

  assign active   = (hcnt >= H_SUP) && (vcnt >= V_SUP);
  assign boundary = (hcnt == '0) && (vcnt == '0);
  assign x        = hcnt - H_SUP;
  assign y        = vcnt - V_SUP;

  // Pixels past the last full bar (HDISP not a multiple of 8) stay in bar 7.
  assign bar_full = x / HW'(BAR_W);
  assign bar_idx  = (bar_full > HW'(7)) ? 3'd7 : bar_full[2:0];

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  always_comb begin
    pattern_rgb = 24'h000000;
    case (mode_q)
      2'd1: pattern_rgb = (((x % HW'(GRID)) == '0) || ((y % VW'(GRID)) == '0)) ? 24'hFFFFFF : 24'h000000;
      2'd2: pattern_rgb = bar_colour(bar_idx);
      2'd3: pattern_rgb = solid_rgb;
      default: pattern_rgb = 24'h000000;
    endcase
  end

  assign fifo_read = (state == ST_STREAM) && active && !fifo_rempty;

  always_comb begin
    pixel_next = 24'h000000;
    if (active) begin
      if (state == ST_STREAM && !fifo_rempty) pixel_next = fifo_rdata[23:0];
      else if (state == ST_PATTERN)           pixel_next = pattern_rgb;
    end
  end

  // Decisions use the mode value being latched, so a frame's state always matches its mode_q.
  always_comb begin
    state_next = state;
    case (state)
      ST_WAIT_PRIME: begin
        if (mode != 2'd0)     state_next = ST_PATTERN;
        else if (fifo_primed) state_next = ST_STREAM;
      end
      ST_STREAM:  if (mode != 2'd0) state_next = ST_PATTERN;
      ST_PATTERN: if (mode == 2'd0) state_next = ST_WAIT_PRIME;
      default:    state_next = ST_WAIT_PRIME;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      hcnt        <= '0;
      vcnt        <= '0;
      HS          <= 1'b1;
      VS          <= 1'b1;
      BLANK       <= 1'b0;
      RGB         <= 24'h000000;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      frame_cnt   <= 16'd0;
      mode_q      <= 2'd0;
      state       <= ST_WAIT_PRIME;
      started     <= 1'b0;
    end else begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end

      HS          <= !((hcnt >= H_PS) && (hcnt < H_PE));
      VS          <= !((vcnt >= V_PS) && (vcnt < V_PE));
      BLANK       <= active;
      RGB         <= pixel_next;
      frame_start <= boundary;

      if ((state == ST_STREAM) && active && fifo_rempty) underflow <= 1'b1;
      else if (underflow_clr)                            underflow <= 1'b0;

      if (boundary) begin
        mode_q  <= mode;
        state   <= state_next;
        started <= 1'b1;
        if (started) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen on a shrunken raster, checked cycle by cycle
// against an arithmetic model of raster position, frame mode and pixel source.
module tb_vga_timing_gen;

  localparam int HDISP = 18, VDISP = 8, HFP = 2, HPULSE = 3, HBP = 2;
  localparam int VFP = 1, VPULSE = 2, VBP = 1, GRID = 4;
  localparam int HSUP = HFP + HPULSE + HBP;
  localparam int HSIZE = HSUP + HDISP;
  localparam int VSUP = VFP + VPULSE + VBP;
  localparam int VSIZE = VSUP + VDISP;
  localparam int FRAME = HSIZE * VSIZE;

  logic        pixel_clk, pixel_rst;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;
  logic        underflow_clr;
  logic [31:0] fifo_rdata;
  logic        fifo_rempty, fifo_primed;
  logic        fifo_read, HS, VS, BLANK, frame_start, underflow;
  logic [23:0] RGB;
  logic [15:0] frame_cnt;

  vga_timing_gen #(
    .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .GRID(GRID)
  ) dut (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .mode(mode), .solid_rgb(solid_rgb),
    .underflow_clr(underflow_clr), .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty),
    .fifo_primed(fifo_primed), .fifo_read(fifo_read), .HS(HS), .VS(VS), .BLANK(BLANK),
    .RGB(RGB), .frame_start(frame_start), .underflow(underflow), .frame_cnt(frame_cnt)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  int n_vec = 0, n_err = 0;
  int c = 0;
  int m_state = 0;          // 0 waiting for prime, 1 streaming, 2 pattern
  int m_mode_q = 0;
  int m_fcnt = 0;
  bit m_started = 0;
  bit m_uf = 0;
  bit rand_fifo = 0, rand_clr = 0, rand_solid = 0, no_empty = 0;
  int rd_cnt = 0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, c);
    end
  endtask

  function automatic logic [23:0] pattern(input int mq, input int x, input int y, input logic [23:0] solid);
    int idx;
    case (mq)
      1: return ((x % GRID) == 0 || (y % GRID) == 0) ? 24'hFFFFFF : 24'h000000;
      2: begin
        idx = x / (HDISP / 8);
        if (idx > 7) idx = 7;
        return bars[idx];
      end
      3: return solid;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic step();
    int h, v, x, y;
    bit act, fs;
    logic exp_rd, exp_hs, exp_vs;
    logic [23:0] exp_rgb;
    h = c % HSIZE;
    v = (c / HSIZE) % VSIZE;
    act = (h >= HSUP) && (v >= VSUP);
    x = h - HSUP;
    y = v - VSUP;
    fs = (h == 0) && (v == 0);
    exp_rd = (m_state == 1) && act && !fifo_rempty;
    exp_rgb = 24'h0;
    if (act && m_state == 1 && !fifo_rempty) exp_rgb = fifo_rdata[23:0];
    if (act && m_state == 2) exp_rgb = pattern(m_mode_q, x, y, solid_rgb);
    exp_hs = !(h >= HFP && h < HFP + HPULSE);
    exp_vs = !(v >= VFP && v < VFP + VPULSE);
    if (m_state == 1 && act && fifo_rempty) m_uf = 1;
    else if (underflow_clr) m_uf = 0;
    if (fs) begin
      if (m_started) m_fcnt = (m_fcnt + 1) % 65536;
      m_started = 1;
      m_mode_q = mode;
      case (m_state)
        0: if (mode != 0) m_state = 2; else if (fifo_primed) m_state = 1;
        1: if (mode != 0) m_state = 2;
        default: if (mode == 0) m_state = 0;
      endcase
    end
    @(negedge pixel_clk);
    check("fifo_read", fifo_read, exp_rd);
    if (fifo_read === 1'b1) rd_cnt++;
    @(posedge pixel_clk);
    #1;
    check("HS", HS, exp_hs);
    check("VS", VS, exp_vs);
    check("BLANK", BLANK, act);
    check("RGB", RGB, exp_rgb);
    check("frame_start", frame_start, fs);
    check("underflow", underflow, m_uf);
    check("frame_cnt", frame_cnt, m_fcnt);
    c++;
    if (rand_fifo) begin
      fifo_rdata = $urandom;
      fifo_rempty = no_empty ? 1'b0 : ($urandom_range(7) == 0);
    end
    if (rand_clr) underflow_clr = ($urandom_range(15) == 0);
    if (rand_solid) solid_rgb = $urandom;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int ht, input int vt);
    for (int i = 0; i <= FRAME && !((c % HSIZE) == ht && ((c / HSIZE) % VSIZE) == vt); i++) step();
  endtask

  initial begin
    pixel_rst = 0; mode = 2'd1; solid_rgb = 24'h123456; underflow_clr = 0;
    fifo_rdata = 32'h0; fifo_rempty = 1; fifo_primed = 0;
    #1 pixel_rst = 1;
    #15 pixel_rst = 0;

    // Grid from the first frame, HS/VS/frame counter over several frames
    rand_fifo = 1;
    run(2 * FRAME + 50);

    // Mid-frame switch to bars takes effect only at the next frame
    run_until(0, VSUP + 2);
    mode = 2'd2;
    run(FRAME);
    mode = 2'd3; rand_solid = 1;
    run(FRAME);
    rand_solid = 0;

    // Stream mode not yet primed, then primed mid-frame
    mode = 2'd0;
    run(2 * FRAME);
    run_until(5, 6);
    fifo_primed = 1; rand_clr = 1;
    run(3 * FRAME);

    // Exactly one pop per active pixel in a frame with no empties
    run_until(0, 0);
    no_empty = 1; fifo_rempty = 0; rd_cnt = 0;
    run(FRAME);
    check("reads_per_frame", rd_cnt, HDISP * VDISP);
    no_empty = 0;

    // Underflow set wins over a simultaneous clear, then held until cleared
    rand_clr = 0; rand_fifo = 0;
    run_until(HSUP + 10, VSUP);
    fifo_rempty = 1; underflow_clr = 1;
    step();
    check("uf_set_wins", underflow, 1'b1);
    fifo_rempty = 0; underflow_clr = 0;
    run(5);
    check("uf_held", underflow, 1'b1);
    underflow_clr = 1;
    step();
    check("uf_cleared", underflow, 1'b0);
    underflow_clr = 0; rand_fifo = 1; rand_clr = 1;

    // Stream -> pattern -> re-prime -> stream
    mode = 2'd1;
    run(FRAME + 10);
    mode = 2'd0;
    run(2 * FRAME);

    // Asynchronous reset in the middle of an active streamed line
    rand_clr = 0;
    run_until(HSUP + 3, VSUP + 2);
    fifo_rempty = 0;
    #1;
    check("pre_rst_read", fifo_read, 1'b1);
    pixel_rst = 1;
    #1;
    check("rst_HS", HS, 1'b1);
    check("rst_VS", VS, 1'b1);
    check("rst_BLANK", BLANK, 1'b0);
    check("rst_RGB", RGB, 24'h0);
    check("rst_fifo_read", fifo_read, 1'b0);
    check("rst_underflow", underflow, 1'b0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    pixel_rst = 0;
    c = 0; m_state = 0; m_mode_q = 0; m_fcnt = 0; m_started = 0; m_uf = 0;
    mode = 2'd1;
    run(FRAME + 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised video timing generator and pixel source for the LCD/VGA output path, in the pixel clock domain. Generates HS/VS/BLANK from per-porch parameters. In stream mode it pops one framebuffer word per active pixel from the read side of the async pixel FIFO. Adds selectable test patterns, frame-aligned start, underflow detection and a frame counter.

Parameters:
HDISP, 800, active pixels per line
VDISP, 480, active lines per frame
HFP, 40, horizontal front porch (pixels)
HPULSE, 48, HS pulse width
HBP, 40, horizontal back porch
VFP, 13, vertical front porch (lines)
VPULSE, 3, VS pulse width
VBP, 29, vertical back porch
GRID, 16, grid pitch for pattern mode; power of 2

Ports:
pixel_clk  in  1  pixel clock; sole clock
pixel_rst  in  1  asynchronous, active-high reset
mode  in  2  0=FIFO stream, 1=grid, 2=colour bars, 3=solid
solid_rgb  in  24  colour for mode 3
underflow_clr  in  1  clears underflow flag
fifo_rdata  in  32  show-ahead FIFO head word; pixel in [23:0] (R[23:16],G[15:8],B[7:0])
fifo_rempty  in  1  FIFO empty
fifo_primed  in  1  FIFO fill threshold reached, already synchronised to pixel_clk
fifo_read  out  1  pop strobe (combinational)
HS  out  1  line sync, active low
VS  out  1  frame sync, active low
BLANK  out  1  1 = active video
RGB  out  24  pixel colour
frame_start  out  1  one-cycle pulse at first cycle of frame
underflow  out  1  sticky underflow flag
frame_cnt  out  16  completed-frame count, wraps

Behaviour:
- Derived values: HSUP=HFP+HPULSE+HBP, HSIZE=HSUP+HDISP, VSUP=VFP+VPULSE+VBP, VSIZE=VSUP+VDISP. Defaults give 928 x 525.
- hcnt runs 0..HSIZE-1. vcnt runs 0..VSIZE-1 and increments when hcnt wraps. vcnt wraps to 0 after VSIZE-1, so line VSIZE is never reached.
- Order within line and frame: front porch, pulse, back porch, active.
- HS low while HFP <= hcnt < HFP+HPULSE. VS low while VFP <= vcnt < VFP+VPULSE.
- Active region: hcnt >= HSUP and vcnt >= VSUP. Pixel coordinates are x=hcnt-HSUP, y=vcnt-VSUP.
- Outputs HS, VS, BLANK, RGB and frame_start are registered and carry one cycle of latency relative to the counters; all are mutually aligned.
- frame_start is asserted in the registered cycle for hcnt=0, vcnt=0. frame_cnt increments at that same boundary; the first frame after reset does not count.
- mode is sampled only at the frame boundary into mode_q; mid-frame changes are ignored.
- State machine:
  - WAIT_PRIME (reset state): no reads; RGB=0 in active region. At the boundary, if mode_q=0 and fifo_primed=1, go to STREAM. If mode_q!=0, go to PATTERN.
  - STREAM: fifo_read=1 when active and !fifo_rempty; registered RGB=fifo_rdata[23:0]. If active and fifo_rempty: no read, RGB=0, underflow<=1. At the boundary, if mode_q!=0 go to PATTERN; otherwise stay.
  - PATTERN: never reads. At the boundary, if mode_q=0 go to WAIT_PRIME (re-priming required).
- Pattern rules:
  - Grid: 24'hFFFFFF when x%GRID==0 or y%GRID==0, else 0.
  - Bars: 8 bars of width HDISP/8, ordered FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. Any remainder pixels take the last bar.
  - Solid: solid_rgb.
- RGB is 0 whenever not active, in all states.
- underflow clears when underflow_clr=1. If set and clear fall in the same cycle, set wins.
- Reset (async, any time): hcnt=vcnt=0, HS=1, VS=1, BLANK=0, RGB=0, frame_start=0, fifo_read=0, underflow=0, frame_cnt=0, mode_q=0, state=WAIT_PRIME. The first frame starts on the first clock after release.

Test Plan:
1. Reset release, mode=1 → HS low during registered cycles for hcnt 40..87; line period 928 cycles. VS low for lines 13..15. frame_start every 487200 cycles; frame_cnt 0→1→2.
2. Grid mode → at x=0,y=0 RGB=FFFFFF; at x=1,y=1 RGB=000000; at x=16,y=1 RGB=FFFFFF; BLANK=0 and RGB=0 at hcnt=127.
3. mode=0 with fifo_primed=0 for 2 frames → fifo_read never high and RGB=0. Raise primed mid-frame → reads begin at the next boundary, exactly 384000 reads per frame, RGB equals the popped word[23:0] one cycle later.
4. STREAM with fifo_rempty=1 at x=10,y=0 → fifo_read low that cycle, RGB=000000, underflow=1 held until underflow_clr. Assert clr and a new underflow together → underflow stays 1.
5. Switch mode 1→2 at line 200 → grid persists to frame end. Next frame bars: x=0 FFFFFF, x=100 FFFF00, x=799 000000.
6. Assert pixel_rst mid-active-line between clock edges → HS=VS=1, BLANK=0, RGB=0, fifo_read=0 immediately. Counters restart at 0 after release.
